// File: rtl/mcu51_inst_fetch.sv
// MCU51 instruction fetch: reads opcode and operand bytes from program
// memory and hands complete 1-3 byte instructions to the decoder.
module mcu51_inst_fetch #(
    parameter int                   ADDRWIDTH = 8,
    parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_pc,
    input  logic [ADDRWIDTH-1:0] new_pc,
    output logic                 mem_cs_n,
    output logic [ADDRWIDTH-1:0] mem_addr,
    input  logic [7:0]           mem_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_op,
    output logic [7:0]           out_b1,
    output logic [7:0]           out_b2,
    output logic [1:0]           out_len,
    output logic [ADDRWIDTH-1:0] out_pc
);

    typedef enum logic [2:0] {
        S_START,
        S_OP,
        S_B1,
        S_B2,
        S_HOLD
    } state_t;

    state_t               state, state_nxt;
    logic                 cs_n_nxt;
    logic [ADDRWIDTH-1:0] addr_nxt;
    logic [7:0]           a_op, a_op_nxt;
    logic [7:0]           a_b1, a_b1_nxt;
    logic [7:0]           a_b2, a_b2_nxt;
    logic [1:0]           a_len, a_len_nxt;
    logic [ADDRWIDTH-1:0] a_pc, a_pc_nxt;
    logic                 ov_nxt;
    logic [7:0]           op_nxt, b1_nxt, b2_nxt;
    logic [1:0]           len_nxt;
    logic [ADDRWIDTH-1:0] pc_nxt;
    logic                 done;
    logic                 take;
    logic [ADDRWIDTH-1:0] addr_inc;

    // Instruction length from the opcode byte.
    function automatic logic [1:0] dec_len(input logic [7:0] op);
        logic [1:0] l;
        unique case (1'b1)
            (op == 8'h75) || (op == 8'h85):
                l = 2'd3;
            (op >= 8'h74) && (op <= 8'h7F) && (op != 8'h75):
                l = 2'd2;
            (op >= 8'h86) && (op <= 8'h8F):
                l = 2'd2;
            (op >= 8'hA6) && (op <= 8'hAF):
                l = 2'd2;
            (op == 8'hE5) || (op == 8'hF5):
                l = 2'd2;
            default:
                l = 2'd1;
        endcase
        return l;
    endfunction

    assign addr_inc = mem_addr + ADDRWIDTH'(1);
    assign take     = !out_valid || out_ready;

    // Next-state, request and assembly logic; jump overrides everything.
    always_comb begin
        state_nxt = state;
        cs_n_nxt  = mem_cs_n;
        addr_nxt  = mem_addr;
        a_op_nxt  = a_op;
        a_b1_nxt  = a_b1;
        a_b2_nxt  = a_b2;
        a_len_nxt = a_len;
        a_pc_nxt  = a_pc;
        ov_nxt    = out_valid;
        op_nxt    = out_op;
        b1_nxt    = out_b1;
        b2_nxt    = out_b2;
        len_nxt   = out_len;
        pc_nxt    = out_pc;
        done      = 1'b0;

        unique case (state)
            S_START: begin
                cs_n_nxt  = 1'b0;
                state_nxt = S_OP;
            end
            S_OP: begin
                a_op_nxt  = mem_data;
                a_pc_nxt  = mem_addr;
                a_len_nxt = dec_len(mem_data);
                a_b1_nxt  = 8'h00;
                a_b2_nxt  = 8'h00;
                if (dec_len(mem_data) == 2'd1) begin
                    done = 1'b1;
                end else begin
                    state_nxt = S_B1;
                    addr_nxt  = addr_inc;
                end
            end
            S_B1: begin
                a_b1_nxt = mem_data;
                if (a_len == 2'd2) begin
                    done = 1'b1;
                end else begin
                    state_nxt = S_B2;
                    addr_nxt  = addr_inc;
                end
            end
            S_B2: begin
                a_b2_nxt = mem_data;
                done     = 1'b1;
            end
            S_HOLD: begin
                done = 1'b1;
            end
            default: begin
                state_nxt = S_START;
                cs_n_nxt  = 1'b1;
            end
        endcase

        if (out_valid && out_ready)
            ov_nxt = 1'b0;

        if (done) begin
            if (take) begin
                ov_nxt    = 1'b1;
                op_nxt    = a_op_nxt;
                b1_nxt    = a_b1_nxt;
                b2_nxt    = a_b2_nxt;
                len_nxt   = a_len_nxt;
                pc_nxt    = a_pc_nxt;
                state_nxt = S_OP;
                addr_nxt  = addr_inc;
                cs_n_nxt  = 1'b0;
            end else begin
                state_nxt = S_HOLD;
                cs_n_nxt  = 1'b1;
            end
        end

        if (ld_pc) begin
            ov_nxt    = 1'b0;
            a_op_nxt  = 8'h00;
            a_b1_nxt  = 8'h00;
            a_b2_nxt  = 8'h00;
            a_len_nxt = 2'd1;
            a_pc_nxt  = new_pc;
            addr_nxt  = new_pc;
            cs_n_nxt  = 1'b0;
            state_nxt = S_OP;
        end
    end

    // State, memory request and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_START;
            mem_cs_n  <= 1'b1;
            mem_addr  <= RESET_PC;
            a_op      <= 8'h00;
            a_b1      <= 8'h00;
            a_b2      <= 8'h00;
            a_len     <= 2'd1;
            a_pc      <= RESET_PC;
            out_valid <= 1'b0;
            out_op    <= 8'h00;
            out_b1    <= 8'h00;
            out_b2    <= 8'h00;
            out_len   <= 2'd1;
            out_pc    <= RESET_PC;
        end else begin
            state     <= state_nxt;
            mem_cs_n  <= cs_n_nxt;
            mem_addr  <= addr_nxt;
            a_op      <= a_op_nxt;
            a_b1      <= a_b1_nxt;
            a_b2      <= a_b2_nxt;
            a_len     <= a_len_nxt;
            a_pc      <= a_pc_nxt;
            out_valid <= ov_nxt;
            out_op    <= op_nxt;
            out_b1    <= b1_nxt;
            out_b2    <= b2_nxt;
            out_len   <= len_nxt;
            out_pc    <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_mcu51_inst_fetch.sv
// Directed bench for mcu51_inst_fetch with a 256-byte program
// memory model that latches on the falling edge.
module tb_mcu51_inst_fetch;

    logic       clk;
    logic       rst_n;
    logic       ld_pc;
    logic [7:0] new_pc;
    logic       mem_cs_n;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_op;
    logic [7:0] out_b1;
    logic [7:0] out_b2;
    logic [1:0] out_len;
    logic [7:0] out_pc;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    mcu51_inst_fetch #(
        .ADDRWIDTH(8),
        .RESET_PC (8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_pc    (ld_pc),
        .new_pc   (new_pc),
        .mem_cs_n (mem_cs_n),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_op   (out_op),
        .out_b1   (out_b1),
        .out_b2   (out_b2),
        .out_len  (out_len),
        .out_pc   (out_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program memory: latch addressed byte on the falling edge.
    always @(negedge clk) begin
        if (!mem_cs_n)
            mem_data <= mem[mem_addr];
        else
            mem_data <= 8'hzz;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic cs,
                           input logic [7:0] a);
        chk({tag, ".cs_n"}, 16'(mem_cs_n), 16'(cs));
        chk({tag, ".addr"}, 16'(mem_addr), 16'(a));
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [7:0] op, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [1:0] len,
                           input logic [7:0] pc);
        chk({tag, ".valid"}, 16'(out_valid), 16'(v));
        chk({tag, ".op"}, 16'(out_op), 16'(op));
        chk({tag, ".b1"}, 16'(out_b1), 16'(b1));
        chk({tag, ".b2"}, 16'(out_b2), 16'(b2));
        chk({tag, ".len"}, 16'(out_len), 16'(len));
        chk({tag, ".pc"}, 16'(out_pc), 16'(pc));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h74; mem[8'h01] = 8'h07;
        mem[8'h02] = 8'hF8; mem[8'h03] = 8'h7F;
        mem[8'h04] = 8'h03; mem[8'h05] = 8'hE6;
        mem[8'h0C] = 8'h75; mem[8'h0D] = 8'h01;
        mem[8'h0E] = 8'h06;
        mem[8'h13] = 8'h86; mem[8'h14] = 8'h20;
        mem[8'hFE] = 8'h85; mem[8'hFF] = 8'h20;

        rst_n = 1'b0;
        ld_pc = 1'b0;
        new_pc = 8'h00;
        out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk_req("rst", 1'b1, 8'h00);
        chk_out("rst", 1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00);
        rst_n = 1'b1;

        // Sequential stream 74 07 / F8 / 7F 03 / E6
        step();
        chk_req("seq.start", 1'b0, 8'h00);
        chk("seq.start.valid", 16'(out_valid), 16'h0);
        step();
        chk_req("seq.a01", 1'b0, 8'h01);
        chk("seq.a01.valid", 16'(out_valid), 16'h0);
        step();
        chk_req("seq.a02", 1'b0, 8'h02);
        chk_out("seq.i0", 1'b1, 8'h74, 8'h07, 8'h00, 2'd2, 8'h00);
        step();
        chk_req("seq.a03", 1'b0, 8'h03);
        chk_out("seq.i1", 1'b1, 8'hF8, 8'h00, 8'h00, 2'd1, 8'h02);
        step();
        chk_req("seq.a04", 1'b0, 8'h04);
        chk("seq.gap.valid", 16'(out_valid), 16'h0);
        step();
        chk_req("seq.a05", 1'b0, 8'h05);
        chk_out("seq.i2", 1'b1, 8'h7F, 8'h03, 8'h00, 2'd2, 8'h03);
        step();
        chk_req("seq.a06", 1'b0, 8'h06);
        chk_out("seq.i3", 1'b1, 8'hE6, 8'h00, 8'h00, 2'd1, 8'h05);

        // Backpressure: hold F8 while 74 07 is not accepted
        ld_pc = 1'b1;
        new_pc = 8'h00;
        step();
        ld_pc = 1'b0;
        chk_req("bp.jmp", 1'b0, 8'h00);
        chk("bp.jmp.valid", 16'(out_valid), 16'h0);
        step();
        chk_req("bp.a01", 1'b0, 8'h01);
        step();
        chk_out("bp.i0", 1'b1, 8'h74, 8'h07, 8'h00, 2'd2, 8'h00);
        out_ready = 1'b0;
        step();
        chk_req("bp.hold1", 1'b1, 8'h02);
        chk_out("bp.hold1", 1'b1, 8'h74, 8'h07, 8'h00, 2'd2, 8'h00);
        step();
        chk_req("bp.hold2", 1'b1, 8'h02);
        chk_out("bp.hold2", 1'b1, 8'h74, 8'h07, 8'h00, 2'd2, 8'h00);
        out_ready = 1'b1;
        step();
        chk_req("bp.resume", 1'b0, 8'h03);
        chk_out("bp.i1", 1'b1, 8'hF8, 8'h00, 8'h00, 2'd1, 8'h02);

        // Jump from S_B1 of 7F 03 to 13 with F8 still pending
        out_ready = 1'b0;
        step();
        chk_req("jmp.b1", 1'b0, 8'h04);
        chk("jmp.keep.valid", 16'(out_valid), 16'h1);
        ld_pc = 1'b1;
        new_pc = 8'h13;
        out_ready = 1'b1;
        step();
        ld_pc = 1'b0;
        chk_req("jmp.ld", 1'b0, 8'h13);
        chk("jmp.flush.valid", 16'(out_valid), 16'h0);
        step();
        chk_req("jmp.a14", 1'b0, 8'h14);
        chk("jmp.a14.valid", 16'(out_valid), 16'h0);
        step();
        chk_out("jmp.i", 1'b1, 8'h86, 8'h20, 8'h00, 2'd2, 8'h13);

        // Three-byte instruction at 0C
        ld_pc = 1'b1;
        new_pc = 8'h0C;
        step();
        ld_pc = 1'b0;
        chk_req("l3.a0c", 1'b0, 8'h0C);
        step();
        chk_req("l3.a0d", 1'b0, 8'h0D);
        step();
        chk_req("l3.a0e", 1'b0, 8'h0E);
        chk("l3.a0e.valid", 16'(out_valid), 16'h0);
        step();
        chk_req("l3.a0f", 1'b0, 8'h0F);
        chk_out("l3.i", 1'b1, 8'h75, 8'h01, 8'h06, 2'd3, 8'h0C);

        // Address wrap FE,FF,00
        mem[8'h00] = 8'h90;
        mem[8'h01] = 8'h75;
        ld_pc = 1'b1;
        new_pc = 8'hFE;
        step();
        ld_pc = 1'b0;
        chk_req("wr.afe", 1'b0, 8'hFE);
        step();
        chk_req("wr.aff", 1'b0, 8'hFF);
        step();
        chk_req("wr.a00", 1'b0, 8'h00);
        out_ready = 1'b0;
        step();
        chk_req("wr.a01", 1'b0, 8'h01);
        chk_out("wr.i", 1'b1, 8'h85, 8'h20, 8'h90, 2'd3, 8'hFE);

        // Reset in S_B2 with an instruction pending
        step();
        chk_req("rs.b1", 1'b0, 8'h02);
        step();
        chk_req("rs.b2", 1'b0, 8'h03);
        chk("rs.b2.valid", 16'(out_valid), 16'h1);
        rst_n = 1'b0;
        #1;
        chk_req("rs.async", 1'b1, 8'h00);
        chk_out("rs.async", 1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00);
        mem[8'h00] = 8'h74;
        mem[8'h01] = 8'h07;
        out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        step();
        chk_req("rs.start", 1'b0, 8'h00);
        step();
        chk_req("rs.a01", 1'b0, 8'h01);
        step();
        chk_out("rs.i", 1'b1, 8'h74, 8'h07, 8'h00, 2'd2, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
